// File: rtl/alu_req_arbiter.sv
// Purpose : shares one combinational ALU between two requesters (round-robin), one op in flight.
// Latency : accept at T, operands on alu_* at T+1, tagged response valid at T+2.
// Backpress: response held stable while rsp_ready_i=0; both request readys stay low until handshake.
module alu_req_arbiter #(
    parameter int unsigned          DATA_W = 32,
    parameter int unsigned          OP_W   = 6,
    parameter logic [OP_W-1:0]      MAX_OP = 6'b001001
) (
    input  logic              clk_i,
    input  logic              arb_rst_i,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [OP_W-1:0]   req0_op_i,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [OP_W-1:0]   req1_op_i,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,

    output logic [OP_W-1:0]   alu_op_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    input  logic [DATA_W-1:0] alu_result_i,

    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_id_o,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                rr_ptr_q, rr_ptr_d;     // port that won the previous grant
    logic                gnt_id_q, gnt_id_d;     // owner of the operation in flight
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                rsp_err_q, rsp_err_d;

    logic                gnt_c;
    logic                accept_c;
    logic                op_illegal_c;

    // Grant selection: a lone requester wins; on a tie the port that did not win last time wins.
    // Readys are masked during reset so nothing looks accepted while the block is held.
    always_comb begin
        gnt_c        = (req0_valid_i && req1_valid_i) ? ~rr_ptr_q : req1_valid_i;
        accept_c     = (state_q == ST_IDLE) && (req0_valid_i || req1_valid_i) && !arb_rst_i;
        req0_ready_o = accept_c && !gnt_c;
        req1_ready_o = accept_c &&  gnt_c;
        op_illegal_c = (alu_op_q > MAX_OP);
    end

    // Next-state and register updates for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_id_d     = gnt_id_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    alu_op_d = gnt_c ? req1_op_i : req0_op_i;
                    alu_a_d  = gnt_c ? req1_a_i  : req0_a_i;
                    alu_b_d  = gnt_c ? req1_b_i  : req0_b_i;
                    gnt_id_d = gnt_c;
                    rr_ptr_d = gnt_c;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Illegal opcodes return zero rather than whatever the ALU produced.
                rsp_err_d    = op_illegal_c;
                rsp_result_d = op_illegal_c ? '0 : alu_result_i;
                rsp_id_d     = gnt_id_q;
                rsp_valid_d  = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight work.
    always_ff @(posedge clk_i or posedge arb_rst_i) begin
        if (arb_rst_i) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= 1'b1;
            gnt_id_q     <= 1'b0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_id_q     <= gnt_id_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_op_o     = alu_op_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_err_o    = rsp_err_q;

endmodule
